mem_stage_lsu: RTL and testbench



---
 rtl/mem_stage_lsu.sv | 144 ++++++++++++++
 tb/tb_mem_stage_lsu.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-access stage: runs loads/stores over a gnt/rvalid data-memory port and formats load data.
// Optional MEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of silently aligning them.
module mem_stage_lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] store_data_in,
    input  logic [2:0]      funct3_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic [4:0]      rd_in,
    input  logic            wb_reg_file_in,
    input  logic            memtoreg_in,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] load_data_out,
    output logic [4:0]      rd_out,
    output logic            wb_reg_file_out,
    output logic            memtoreg_out,
    output logic            stall_out,
    output logic            misalign_exc_out
);

    // state    | meaning
    // IDLE     | no access in flight; a live memory op is latched here
    // REQ      | dmem_req high, waiting for gnt
    // WAIT_RSP | load granted, waiting for rvalid
    // DONE     | one cycle with stall low so MEM/WB captures the result
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t          state;
    logic            mem_op;
    logic            trapped;
    logic [1:0]      a;
    logic [3:0]      st_strb;
    logic [XLEN-1:0] st_data;
    logic [2:0]      ld_f3;
    logic [1:0]      ld_off;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] ld_fmt;

    assign a      = alu_result_in[1:0];
    assign mem_op = valid_in & (mem_read_in | mem_write_in);

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((funct3_in[1:0] == 2'b01) & a[0]) |
                        (funct3_in[1] & (a != 2'b00));
    assign trapped    = (state == IDLE) & mem_op & misaligned;
`else
    assign trapped    = 1'b0;
`endif

    always_comb begin
        st_strb = 4'b1111;
        st_data = store_data_in;
        case (funct3_in[1:0])
            2'b00: begin
                st_strb = 4'b0001 << a;
                st_data = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << {a[1], 1'b0};
                st_data = {2{store_data_in[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = store_data_in;
            end
        endcase
    end

    // Lane selection uses the offset latched with the request, not the live EX/MEM value.
    always_comb begin
        byte_sel = dmem_rdata[{ld_off, 3'b000} +: 8];
        half_sel = ld_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (ld_f3)
            3'b000:  ld_fmt = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b001:  ld_fmt = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b100:  ld_fmt = {{(XLEN-8){1'b0}}, byte_sel};
            3'b101:  ld_fmt = {{(XLEN-16){1'b0}}, half_sel};
            default: ld_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_wstrb    <= '0;
            dmem_we       <= 1'b0;
            ld_f3         <= '0;
            ld_off        <= '0;
            load_data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op & ~trapped) begin
                        dmem_addr  <= {alu_result_in[XLEN-1:2], 2'b00};
                        dmem_we    <= ~mem_read_in;
                        dmem_wdata <= st_data;
                        dmem_wstrb <= mem_read_in ? 4'b0000 : st_strb;
                        ld_f3      <= funct3_in;
                        ld_off     <= a;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (dmem_gnt) state <= dmem_we ? DONE : WAIT_RSP;
                end
                WAIT_RSP: begin
                    if (dmem_rvalid) begin
                        load_data_out <= ld_fmt;
                        state         <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dmem_req         = rst_n & (state == REQ);
    assign stall_out        = rst_n & (((state == IDLE) & mem_op & ~trapped) |
                                       (state == REQ) | (state == WAIT_RSP));
    assign misalign_exc_out = rst_n & trapped;

    assign alu_result_out   = rst_n ? alu_result_in : '0;
    assign rd_out           = rst_n ? rd_in : 5'd0;
    assign wb_reg_file_out  = rst_n & wb_reg_file_in & ~trapped;
    assign memtoreg_out     = rst_n & memtoreg_in;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu; covers both MEM_MISALIGN_TRAP_EN builds.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic [2:0]  funct3_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [4:0]  rd_in;
    logic        wb_reg_file_in;
    logic        memtoreg_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] alu_result_out;
    logic [31:0] load_data_out;
    logic [4:0]  rd_out;
    logic        wb_reg_file_out;
    logic        memtoreg_out;
    logic        stall_out;
    logic        misalign_exc_out;

    int n_assert = 0;
    int n_fail   = 0;
    int stalls;

    logic        req_seen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_we;

    always #5 clk = ~clk;

    mem_stage_lsu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .alu_result_in(alu_result_in), .store_data_in(store_data_in),
        .funct3_in(funct3_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .rd_in(rd_in), .wb_reg_file_in(wb_reg_file_in), .memtoreg_in(memtoreg_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .alu_result_out(alu_result_out), .load_data_out(load_data_out),
        .rd_out(rd_out), .wb_reg_file_out(wb_reg_file_out), .memtoreg_out(memtoreg_out),
        .stall_out(stall_out), .misalign_exc_out(misalign_exc_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rd_en, input logic wr_en,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] rd,
                         input logic wb, input logic m2r);
        valid_in       = v;
        mem_read_in    = rd_en;
        mem_write_in   = wr_en;
        funct3_in      = f3;
        alu_result_in  = addr;
        store_data_in  = sd;
        rd_in          = rd;
        wb_reg_file_in = wb;
        memtoreg_in    = m2r;
    endtask

    // Called right after a negedge with the op already driven; returns inside DONE.
    task automatic run_access(input int gnt_dly, input int rv_dly,
                              input logic [31:0] rdata, output int n_stall);
        int  req_n   = 0;
        int  wait_n  = 0;
        bit  granted = 0;
        bit  done    = 0;
        n_stall  = 0;
        req_seen = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            #1;
            if (!stall_out) begin
                done = 1;
            end else begin
                n_stall++;
                dmem_gnt    = 1'b0;
                dmem_rvalid = 1'b0;
                dmem_rdata  = rdata;
                if (dmem_req) begin
                    if (!req_seen) begin
                        req_seen  = 1'b1;
                        req_addr  = dmem_addr;
                        req_wdata = dmem_wdata;
                        req_wstrb = dmem_wstrb;
                        req_we    = dmem_we;
                    end
                    if (req_n == gnt_dly) begin
                        dmem_gnt = 1'b1;
                        granted  = 1;
                    end
                    req_n++;
                end else if (granted) begin
                    if (wait_n == rv_dly) dmem_rvalid = 1'b1;
                    wait_n++;
                end
                @(negedge clk);
            end
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        chk("access_completes", {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        drive(1, 1, 0, 3'b010, 32'h0000_0055, 32'h0, 5'd7, 1, 1);
        #3;
        chk("rst_alu_out", alu_result_out, 32'h0);
        chk("rst_rd_out", {27'd0, rd_out}, 32'h0);
        chk("rst_wb_out", {31'd0, wb_reg_file_out}, 32'h0);
        chk("rst_m2r_out", {31'd0, memtoreg_out}, 32'h0);
        chk("rst_stall", {31'd0, stall_out}, 32'h0);
        chk("rst_req", {31'd0, dmem_req}, 32'h0);
        chk("rst_ldata", load_data_out, 32'h0);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // LW 0x100, gnt in second REQ cycle, rvalid next cycle
        drive(1, 1, 0, 3'b010, 32'h0000_0100, 32'h0, 5'd3, 1, 1);
        run_access(1, 0, 32'hDEAD_BEEF, stalls);
        chk("lw_stalls", stalls, 32'd4);
        chk("lw_addr", req_addr, 32'h0000_0100);
        chk("lw_we", {31'd0, req_we}, 32'h0);
        chk("lw_data", load_data_out, 32'hDEAD_BEEF);
        chk("lw_m2r", {31'd0, memtoreg_out}, 32'h1);
        chk("lw_rd", {27'd0, rd_out}, 32'd3);
        chk("lw_misalign", {31'd0, misalign_exc_out}, 32'h0);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        @(negedge clk);

        // LB / LBU at 0x103, minimum latency
        drive(1, 1, 0, 3'b000, 32'h0000_0103, 32'h0, 5'd4, 1, 1);
        run_access(0, 0, 32'h80FF_FFFF, stalls);
        chk("lb_stalls", stalls, 32'd3);
        chk("lb_data", load_data_out, 32'hFFFF_FF80);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        @(negedge clk);
        drive(1, 1, 0, 3'b100, 32'h0000_0103, 32'h0, 5'd4, 1, 1);
        run_access(0, 0, 32'h80FF_FFFF, stalls);
        chk("lbu_data", load_data_out, 32'h0000_0080);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        @(negedge clk);

        // LH upper half, slow rvalid; LHU lower half
        drive(1, 1, 0, 3'b001, 32'h0000_0102, 32'h0, 5'd5, 1, 1);
        run_access(0, 2, 32'h8001_1234, stalls);
        chk("lh_stalls", stalls, 32'd5);
        chk("lh_data", load_data_out, 32'hFFFF_8001);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        @(negedge clk);
        drive(1, 1, 0, 3'b101, 32'h0000_0100, 32'h0, 5'd5, 1, 1);
        run_access(0, 0, 32'h0000_F00D, stalls);
        chk("lhu_data", load_data_out, 32'h0000_F00D);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        @(negedge clk);

        // SH 0x202
        drive(1, 0, 1, 3'b001, 32'h0000_0202, 32'h0000_1234, 5'd0, 0, 0);
        run_access(0, 0, 32'h0, stalls);
        chk("sh_stalls", stalls, 32'd2);
        chk("sh_addr", req_addr, 32'h0000_0200);
        chk("sh_wstrb", {28'd0, req_wstrb}, 32'h0000_000C);
        chk("sh_wdata", req_wdata, 32'h1234_1234);
        chk("sh_we", {31'd0, req_we}, 32'h1);
        chk("sh_ldata_hold", load_data_out, 32'h0000_F00D);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        @(negedge clk);

        // SB 0x201
        drive(1, 0, 1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 5'd0, 0, 0);
        run_access(0, 0, 32'h0, stalls);
        chk("sb_wstrb", {28'd0, req_wstrb}, 32'h0000_0002);
        chk("sb_wdata", req_wdata, 32'hABAB_ABAB);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        @(negedge clk);

        // SW 0x300 with slow grant
        drive(1, 0, 1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 5'd0, 0, 0);
        run_access(3, 0, 32'h0, stalls);
        chk("sw_stalls", stalls, 32'd5);
        chk("sw_wstrb", {28'd0, req_wstrb}, 32'h0000_000F);
        chk("sw_wdata", req_wdata, 32'hCAFE_F00D);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        @(negedge clk);

        // Non-memory ADD passes straight through
        drive(1, 0, 0, 3'b000, 32'h0000_0055, 32'h0, 5'd9, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("add_alu", alu_result_out, 32'h0000_0055);
            chk("add_stall", {31'd0, stall_out}, 32'h0);
            chk("add_req", {31'd0, dmem_req}, 32'h0);
            @(negedge clk);
        end
        chk("add_wb", {31'd0, wb_reg_file_out}, 32'h1);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        @(negedge clk);

        // Misaligned LW 0x101
        drive(1, 1, 0, 3'b010, 32'h0000_0101, 32'h0, 5'd6, 1, 1);
`ifdef MEM_MISALIGN_TRAP_EN
        #1;
        chk("mis_exc", {31'd0, misalign_exc_out}, 32'h1);
        chk("mis_wb", {31'd0, wb_reg_file_out}, 32'h0);
        chk("mis_stall", {31'd0, stall_out}, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        #1;
        chk("mis_no_req", {31'd0, dmem_req}, 32'h0);
        chk("mis_exc_clear", {31'd0, misalign_exc_out}, 32'h0);
`else
        #1;
        chk("mis_exc_tied", {31'd0, misalign_exc_out}, 32'h0);
        chk("mis_wb", {31'd0, wb_reg_file_out}, 32'h1);
        run_access(0, 0, 32'h1111_2222, stalls);
        chk("mis_addr", req_addr, 32'h0000_0100);
        chk("mis_data", load_data_out, 32'h1111_2222);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
`endif
        @(negedge clk);

        // Read and write together: treated as a load
        drive(1, 1, 1, 3'b010, 32'h0000_0400, 32'h9999_9999, 5'd8, 1, 1);
        run_access(0, 0, 32'h7654_3210, stalls);
        chk("rw_we", {31'd0, req_we}, 32'h0);
        chk("rw_stalls", stalls, 32'd3);
        chk("rw_data", load_data_out, 32'h7654_3210);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        @(negedge clk);

        // Reset while waiting for rvalid
        drive(1, 1, 0, 3'b010, 32'h0000_0500, 32'h0, 5'd10, 1, 1);
        @(negedge clk);
        dmem_gnt = 1'b1;
        #1;
        chk("rw_req_up", {31'd0, dmem_req}, 32'h1);
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        chk("wait_stall", {31'd0, stall_out}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstw_req", {31'd0, dmem_req}, 32'h0);
        chk("rstw_stall", {31'd0, stall_out}, 32'h0);
        chk("rstw_alu", alu_result_out, 32'h0);
        chk("rstw_wb", {31'd0, wb_reg_file_out}, 32'h0);
        chk("rstw_ldata", load_data_out, 32'h0);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        @(negedge clk);
        rst_n       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        chk("late_rvalid_ldata", load_data_out, 32'h0);
        chk("late_rvalid_stall", {31'd0, stall_out}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
